// File: rtl/spu_pkg.sv
// Shared types and constants for the SPU instruction front end.
package spu_pkg;

  localparam int PC_WIDTH   = 15;
  localparam int INST_WIDTH = 32;
  localparam int PAIR_WIDTH = 2 * INST_WIDTH;

  localparam logic [INST_WIDTH-1:0] INST_NOP = 32'hFFFF_FFFF;
  localparam logic [PAIR_WIDTH-1:0] PAIR_NOP = {2{INST_NOP}};

  typedef enum logic [1:0] {IDLE, RUN, REDIRECT} fetch_state_t;

  typedef struct packed {
    logic [PAIR_WIDTH-1:0] pair;
    logic [PC_WIDTH-1:0]   pc;
  } fetch_entry_t;

  function automatic logic [PC_WIDTH-1:0] pair_align(input logic [PC_WIDTH-1:0] addr);
    return {addr[PC_WIDTH-1:3], 3'b000};
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Decoder, branch and instruction-memory signals of the fetch unit.
interface instruction_fetch_if;
  import spu_pkg::*;

  // instOut is consumed at a clock edge where instValid=1 and stallIn=0;
  // memData answers a memRdEn exactly one cycle later.
  logic                  stallIn;
  logic                  branchValid;
  logic [PC_WIDTH-1:0]   branchTarget;
  logic                  memRdEn;
  logic [PC_WIDTH-1:0]   memAddr;
  logic [PAIR_WIDTH-1:0] memData;
  logic [PAIR_WIDTH-1:0] instOut;
  logic                  instValid;
  logic [PC_WIDTH-1:0]   pcOut;

  modport master (
    input  stallIn, branchValid, branchTarget, memData,
    output memRdEn, memAddr, instOut, instValid, pcOut
  );

  modport slave (
    output stallIn, branchValid, branchTarget, memData,
    input  memRdEn, memAddr, instOut, instValid, pcOut
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched instruction pairs with flush.
module fetch_fifo
  import spu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_entry,
  output fetch_entry_t rd_entry,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic           do_push, do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full && !flush;
  assign do_pop   = pop && !empty && !flush;
  assign rd_entry = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch unit: issues pair reads, buffers responses, redirects on branch.
module instruction_fetch
  import spu_pkg::*;
#(
  parameter int fifoDepth = 4
) (
  input  logic                clk,
  input  logic                reset,
  instruction_fetch_if.master bus,
  output fetch_state_t        fsm_state
);

  localparam int CW = $clog2(fifoDepth) + 1;

  fetch_state_t        state, state_nxt;
  logic [PC_WIDTH-1:0] pc, inflight_pc;
  logic                inflight, skip_low;
  logic                branch_take, issue, push, pop, credit_ok;
  logic [CW-1:0]       count;
  logic [CW:0]         used;
  logic                full, empty;
  fetch_entry_t        wr_entry, head;
  logic                unused_target_bits;

  assign branch_take = bus.branchValid && (state != IDLE);
  assign used        = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign credit_ok   = (used < (CW + 1)'(fifoDepth));

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE:     state_nxt = RUN;
      RUN: begin
        issue = credit_ok && !branch_take;
        if (branch_take) state_nxt = REDIRECT;
      end
      REDIRECT: if (!branch_take) state_nxt = RUN;
      default:  state_nxt = IDLE;
    endcase
  end

  // A branch discards the response due this cycle; clearing inflight kills the next one.
  assign push = inflight && !branch_take;
  assign pop  = !empty && !bus.stallIn;

  always_comb begin
    wr_entry      = '0;
    wr_entry.pair = {bus.memData[PAIR_WIDTH-1:INST_WIDTH],
                     skip_low ? INST_NOP : bus.memData[INST_WIDTH-1:0]};
    wr_entry.pc   = inflight_pc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pc          <= '0;
      inflight_pc <= '0;
      inflight    <= 1'b0;
      skip_low    <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= issue;
      if (issue) inflight_pc <= pc;
      if (branch_take) begin
        pc       <= pair_align(bus.branchTarget);
        skip_low <= bus.branchTarget[2];
      end else begin
        if (issue) pc <= pc + PC_WIDTH'(8);
        if (push)  skip_low <= 1'b0;
      end
    end
  end

  fetch_fifo #(.DEPTH(fifoDepth)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .flush    (branch_take),
    .wr_entry (wr_entry),
    .rd_entry (head),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  assign bus.memRdEn   = issue;
  assign bus.memAddr   = pc;
  assign bus.instValid = !empty;
  assign bus.instOut   = empty ? PAIR_NOP : head.pair;
  assign bus.pcOut     = empty ? '0 : head.pc;
  assign fsm_state     = state;

  assign unused_target_bits = ^bus.branchTarget[1:0];

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch with a memory model and pair scoreboard.
module tb_instruction_fetch;
  import spu_pkg::*;

  localparam int W = PAIR_WIDTH + PC_WIDTH;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instruction_fetch_if bus();
  fetch_state_t fsm_state;

  instruction_fetch #(.fifoDepth(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  logic [W-1:0]        exp_q[$];
  logic [PC_WIDTH-1:0] exp_addr;
  int n_cmp = 0;
  int n_bad = 0;
  int overflow_cnt = 0;
  int lat;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [PC_WIDTH-1:0] a, input bit skip);
    logic [INST_WIDTH-1:0] lo, hi;
    lo = skip ? INST_NOP : {17'b0, a};
    hi = {17'b0, a + PC_WIDTH'(4)};
    return {hi, lo, a};
  endfunction

  task automatic fill_exp(input logic [PC_WIDTH-1:0] start, input bit odd);
    logic [PC_WIDTH-1:0] a;
    a = start;
    exp_q.delete();
    for (int i = 0; i < 300; i++) begin
      exp_q.push_back(mk(a, odd && (i == 0)));
      a = a + PC_WIDTH'(8);
    end
    exp_addr = start;
  endtask

  // Instruction local store: mem[a] = {a+4, a}, one-cycle read latency.
  always @(posedge clk) begin
    if (bus.memRdEn)
      bus.memData <= {17'b0, bus.memAddr + PC_WIDTH'(4), 17'b0, bus.memAddr};
  end

  always @(posedge clk) begin
    if (reset && dut.push && dut.full) overflow_cnt++;
  end

  // Scoreboard: every issued address and every consumed pair is checked in order.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.memRdEn) begin
        check("mem_addr", W'(bus.memAddr), W'(exp_addr));
        exp_addr = exp_addr + PC_WIDTH'(8);
      end
      if (bus.instValid && !bus.stallIn) begin
        if (exp_q.size() == 0) check("exp_underflow", W'(1), W'(0));
        else check("pair", {bus.instOut, bus.pcOut}, exp_q.pop_front());
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max, output int l);
    l = 0;
    do begin
      @(posedge clk);
      l++;
      @(negedge clk);
    end while (!bus.instValid && l < max);
    #1;
  endtask

  task automatic branch_to(input logic [PC_WIDTH-1:0] tgt);
    bus.branchTarget = tgt;
    bus.branchValid  = 1'b1;
    @(posedge clk);
    #1;
    bus.branchValid = 1'b0;
    bus.stallIn     = 1'b0;
    fill_exp(pair_align(tgt), tgt[2]);
    @(negedge clk);
    check("branch_valid_drop", W'(bus.instValid), W'(0));
    wait_valid(20, lat);
    check("branch_latency", W'(lat), W'(3));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, W'(bus.instValid), W'(0));
    check({tag, "_inst"},  W'(bus.instOut), W'(PAIR_NOP));
    check({tag, "_pc"},    W'(bus.pcOut), W'(0));
    check({tag, "_rden"},  W'(bus.memRdEn), W'(0));
    check({tag, "_addr"},  W'(bus.memAddr), W'(0));
    check({tag, "_state"}, W'(fsm_state), W'(IDLE));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset            = 1'b0;
    bus.stallIn      = 1'b0;
    bus.branchValid  = 1'b0;
    bus.branchTarget = '0;
    fill_exp('0, 1'b0);
    #12;
    check_reset_values("reset");

    // Release and measure first-pair latency.
    @(negedge clk);
    reset = 1'b1;
    wait_valid(20, lat);
    check("reset_latency", W'(lat), W'(3));
    check("state_run", W'(fsm_state), W'(RUN));
    cycles(15);

    // Stall hold: the head pair must stay put while the buffer fills.
    bus.stallIn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", W'(bus.instValid), W'(1));
      check("stall_hold", {bus.instOut, bus.pcOut}, exp_q[0]);
      if (i == 4) begin
        check("stall_count", W'(dut.count), W'(4));
        check("stall_rden", W'(bus.memRdEn), W'(0));
      end
      @(posedge clk);
      #1;
    end
    bus.stallIn = 1'b0;
    cycles(10);

    // Branch while stalled with three pairs buffered.
    bus.stallIn = 1'b1;
    cycles(2);
    branch_to(15'h0100);
    check("branch_first_pc", W'(bus.pcOut), W'(15'h0100));
    cycles(10);

    // Odd target: only the target instruction issues from the first pair.
    branch_to(15'h0104);
    check("odd_first_pair", {bus.instOut, bus.pcOut}, mk(15'h0100, 1'b1));
    cycles(10);

    // Wrap through the top of the local store.
    branch_to(15'h7FE0);
    cycles(12);

    // Asynchronous reset mid-cycle during a stall with a full buffer.
    bus.stallIn = 1'b1;
    cycles(6);
    #2;
    reset = 1'b0;
    #1;
    check_reset_values("async");
    fill_exp('0, 1'b0);
    bus.stallIn = 1'b0;
    @(negedge clk);
    #2;
    reset = 1'b1;
    wait_valid(20, lat);
    check("async_latency", W'(lat), W'(3));
    check("async_first_pc", W'(bus.pcOut), W'(0));

    // Random stall traffic.
    for (int i = 0; i < 200; i++) begin
      bus.stallIn = ($urandom_range(0, 3) == 0);
      cycles(1);
    end
    bus.stallIn = 1'b0;
    cycles(5);

    check("no_overflow", W'(overflow_cnt), W'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
